// File: rtl/vdma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdma_pkg
// Description : Shared VDMA definitions. Holds the clog2 helper, the FIFO
//               default depth/width/threshold constants and the FIFO status
//               flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package vdma_pkg;

    localparam int c_FIFO_WIDTH     = 32;
    localparam int c_FIFO_DEPTH     = 16;
    localparam int c_FIFO_AFULL_TH  = 12;
    localparam int c_FIFO_AEMPTY_TH = 2;

    // FIFO status flags, registered together as one bundle
    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdma_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : vdma_fifo_ram
// Description : Simple dual-port RAM, WIDTH x DEPTH, one write port and one
//               registered read port. The array has no reset; only the read
//               register is cleared so the FIFO output starts at zero.
// Ports       : clk, reset (sync, active-low, read register only)
//               we/waddr/wdata  - write port
//               re/raddr/rdata  - registered read port, rdata holds when re=0
// Revision    : 1.0 - initial release
// ============================================================================
module vdma_fifo_ram
    import vdma_pkg::*;
#(
    parameter int WIDTH  = c_FIFO_WIDTH,
    parameter int DEPTH  = c_FIFO_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;
    logic [WIDTH-1:0] w_rdata_d;

    // Array kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_comb begin
        w_rdata_d = r_rdata_q;
        if (re) begin
            w_rdata_d = r_mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/vdma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vdma_sync_fifo
// Description : Single-clock synchronous FIFO for the VDMA datapath with
//               registered full/afull/empty/aempty flags, occupancy count,
//               one-cycle read latency and overflow/underflow pulses.
// Ports       : clk, reset (sync, active-low)
//               we, wdata           - write request / data
//               re, rdata, rvalid   - read request / data / data valid
//               full, afull, empty, aempty - registered status flags
//               count               - occupancy 0..DEPTH
//               overflow, underflow - registered illegal-access pulses
// Revision    : 1.0 - initial release
// ============================================================================
module vdma_sync_fifo
    import vdma_pkg::*;
#(
    parameter int WIDTH     = c_FIFO_WIDTH,
    parameter int DEPTH     = c_FIFO_DEPTH,
    parameter int AFULL_TH  = c_FIFO_AFULL_TH,
    parameter int AEMPTY_TH = c_FIFO_AEMPTY_TH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   re,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   full,
    output logic                   afull,
    output logic                   empty,
    output logic                   aempty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] c_depth_cnt  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull_th   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] c_aempty_th  = CNT_W'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] c_ptr_one   = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wptr_q, w_wptr_d;
    logic [ADDR_W-1:0] r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0]  r_count_q, w_count_d;
    fifo_flags_t       r_flags_q, w_flags_d;
    logic              r_rvalid_q, w_rvalid_d;
    logic              r_overflow_q, w_overflow_d;
    logic              r_underflow_q, w_underflow_d;

    logic              w_wr_ok;
    logic              w_rd_ok;

    // Accepts are qualified by reset so nothing reaches the RAM while held
    assign w_wr_ok = reset & we & ~r_flags_q.full;
    assign w_rd_ok = reset & re & ~r_flags_q.empty;

    always_comb begin
        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_count_d     = r_count_q + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);
        w_rvalid_d    = w_rd_ok;
        w_overflow_d  = we & r_flags_q.full;
        w_underflow_d = re & r_flags_q.empty;

        if (w_wr_ok) begin
            w_wptr_d = r_wptr_q + c_ptr_one;
        end
        if (w_rd_ok) begin
            w_rptr_d = r_rptr_q + c_ptr_one;
        end

        // Flags follow the next occupancy so they line up with count
        w_flags_d.full   = (w_count_d == c_depth_cnt);
        w_flags_d.afull  = (w_count_d >= c_afull_th);
        w_flags_d.empty  = (w_count_d == '0);
        w_flags_d.aempty = (w_count_d <= c_aempty_th);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr_q         <= '0;
            r_rptr_q         <= '0;
            r_count_q        <= '0;
            r_flags_q.full   <= 1'b0;
            r_flags_q.afull  <= 1'b0;
            r_flags_q.empty  <= 1'b1;
            r_flags_q.aempty <= 1'b1;
            r_rvalid_q       <= 1'b0;
            r_overflow_q     <= 1'b0;
            r_underflow_q    <= 1'b0;
        end else begin
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_count_q     <= w_count_d;
            r_flags_q     <= w_flags_d;
            r_rvalid_q    <= w_rvalid_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    vdma_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (w_wr_ok),
        .waddr  (r_wptr_q),
        .wdata  (wdata),
        .re     (w_rd_ok),
        .raddr  (r_rptr_q),
        .rdata  (rdata)
    );

    assign rvalid    = r_rvalid_q;
    assign full      = r_flags_q.full;
    assign afull     = r_flags_q.afull;
    assign empty     = r_flags_q.empty;
    assign aempty    = r_flags_q.aempty;
    assign count     = r_count_q;
    assign overflow  = r_overflow_q;
    assign underflow = r_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vdma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdma_sync_fifo
// Description : Directed self-checking bench for vdma_sync_fifo
//               (WIDTH=32, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdma_sync_fifo;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic        full;
    logic        afull;
    logic        empty;
    logic        aempty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_q[$];
    int          m_count = 0;
    logic [31:0] m_rdata = '0;
    logic        m_rvalid = 1'b0;
    logic        m_ov = 1'b0;
    logic        m_un = 1'b0;
    logic        last_wr;
    logic        last_rd;

    vdma_sync_fifo #(
        .WIDTH     (32),
        .DEPTH     (16),
        .AFULL_TH  (12),
        .AEMPTY_TH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wdata     (wdata),
        .re        (re),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .full      (full),
        .afull     (afull),
        .empty     (empty),
        .aempty    (aempty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ph);
        chk({ph, ":count"},     {27'd0, count},       m_count);
        chk({ph, ":full"},      {31'd0, full},        {31'd0, m_count == 16});
        chk({ph, ":afull"},     {31'd0, afull},       {31'd0, m_count >= 12});
        chk({ph, ":empty"},     {31'd0, empty},       {31'd0, m_count == 0});
        chk({ph, ":aempty"},    {31'd0, aempty},      {31'd0, m_count <= 2});
        chk({ph, ":rvalid"},    {31'd0, rvalid},      {31'd0, m_rvalid});
        chk({ph, ":rdata"},     rdata,                m_rdata);
        chk({ph, ":overflow"},  {31'd0, overflow},    {31'd0, m_ov});
        chk({ph, ":underflow"}, {31'd0, underflow},   {31'd0, m_un});
    endtask

    // One clock with reset released; model evaluated from pre-edge state
    task automatic step(input string ph, input logic w, input logic r, input logic [31:0] d);
        logic wr, rd;
        @(negedge clk);
        reset = 1'b1;
        we    = w;
        re    = r;
        wdata = d;
        wr = w && (m_count != 16);
        rd = r && (m_count != 0);
        m_ov = w && (m_count == 16);
        m_un = r && (m_count == 0);
        m_rvalid = rd;
        if (rd) m_rdata = m_q.pop_front();
        if (wr) m_q.push_back(d);
        m_count = m_count + (wr ? 1 : 0) - (rd ? 1 : 0);
        last_wr = wr;
        last_rd = rd;
        @(posedge clk);
        #1;
        chk_all(ph);
    endtask

    task automatic do_reset(input string ph, input int n, input logic w, input logic r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            we    = w;
            re    = r;
            wdata = 32'hDEAD_0000 + i;
            @(posedge clk);
            #1;
        end
        m_q.delete();
        m_count  = 0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ov     = 1'b0;
        m_un     = 1'b0;
        chk_all(ph);
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
    endtask

    initial begin
        int wn, rn;
        reset = 1'b0;
        we    = 1'b1;
        re    = 1'b1;
        wdata = '0;

        // Reset held 3 cycles with both requests high
        do_reset("reset", 3, 1'b1, 1'b1);

        // Fill 0..15, then an overflowing 17th write
        for (int i = 0; i < 16; i++) begin
            step("fill", 1'b1, 1'b0, i);
            if (i == 10) chk("fill_afull_11", {31'd0, afull}, 32'd0);
            if (i == 11) chk("fill_afull_12", {31'd0, afull}, 32'd1);
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count16", {27'd0, count}, 32'd16);
        step("ovf", 1'b1, 1'b0, 32'hAA);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        step("ovf_clr", 1'b0, 1'b0, 32'h0);
        chk("ovf_one_cycle", {31'd0, overflow}, 32'd0);

        // Drain: read data appears one cycle after each read
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, 1'b1, 32'h0);
            chk("drain_data", rdata, i);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        step("unf", 1'b0, 1'b1, 32'h0);
        chk("unf_pulse", {31'd0, underflow}, 32'd1);
        chk("unf_rvalid", {31'd0, rvalid}, 32'd0);
        chk("unf_rdata_hold", rdata, 32'hF);

        // Simultaneous at count 5
        for (int i = 0; i < 5; i++) step("sim_pre", 1'b1, 1'b0, 32'h100 + i);
        for (int i = 0; i < 10; i++) begin
            step("sim", 1'b1, 1'b1, 32'h200 + i);
            chk("sim_count5", {27'd0, count}, 32'd5);
        end
        chk("sim_order", rdata, 32'h204);

        // Both high while full
        for (int i = 0; i < 11; i++) step("sim_fill", 1'b1, 1'b0, 32'h300 + i);
        chk("sim_full", {31'd0, full}, 32'd1);
        step("full_both", 1'b1, 1'b1, 32'hBB);
        chk("full_both_count", {27'd0, count}, 32'd15);
        chk("full_both_ovf", {31'd0, overflow}, 32'd1);

        // Drain and both high while empty
        for (int i = 0; i < 15; i++) step("sim_drain", 1'b0, 1'b1, 32'h0);
        step("empty_both", 1'b1, 1'b1, 32'hCC);
        chk("empty_both_count", {27'd0, count}, 32'd1);
        chk("empty_both_unf", {31'd0, underflow}, 32'd1);
        step("empty_both_rd", 1'b0, 1'b1, 32'h0);
        step("empty_both_out", 1'b0, 1'b0, 32'h0);
        chk("empty_both_data", rdata, 32'hCC);

        // Wrap-around: 40 words at random duty
        wn = 0;
        rn = 0;
        for (int cyc = 0; cyc < 600 && (wn < 40 || rn < 40); cyc++) begin
            step("wrap", (wn < 40) && ($urandom_range(0, 1) == 1),
                 (rn < 40) && ($urandom_range(0, 2) != 0), 32'h1000 + wn);
            if (last_wr) wn++;
            if (last_rd) rn++;
        end
        chk("wrap_writes", wn, 40);
        chk("wrap_reads", rn, 40);
        step("wrap_tail", 1'b0, 1'b0, 32'h0);

        // Reset mid-operation with a read pending
        for (int i = 0; i < 9; i++) step("mid_pre", 1'b1, 1'b0, 32'h400 + i);
        chk("mid_count9", {27'd0, count}, 32'd9);
        step("mid_rd", 1'b0, 1'b1, 32'h0);
        do_reset("mid_reset", 1, 1'b0, 1'b1);
        chk("mid_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_count0", {27'd0, count}, 32'd0);
        step("post_wr", 1'b1, 1'b0, 32'h55);
        step("post_rd", 1'b0, 1'b1, 32'h0);
        chk("post_data", rdata, 32'h55);
        chk("post_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
